// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, FSM state encoding and helper arithmetic.
// Both the transmitter and the receiver use this package.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } uart_state_e;

  // Clocks per bit, rounded to the nearest integer.
  function automatic int calc_div(input longint f, input longint baud);
    return int'((f + baud / 2) / baud);
  endfunction

  // Unused high bits must be zero; they do not disturb the XOR.
  function automatic logic parity_of(input logic [8:0] bits, input int mode);
    return (mode == PARITY_ODD) ? ~(^bits) : (^bits);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time counter: tick marks the last clk of each DIV-clk bit period.
// clear holds the count at zero so the first bit after leaving idle is full length.
module uart_baud_gen #(
  parameter int DIV = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count;

  assign tick = (count == LAST);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // always_ff reads the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start bit, DATA_BITS LSB first, optional parity,
// one or two stop bits. ready is high only in IDLE; done marks the final stop clk.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int F         = 50000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 done
);

  localparam int DIV = calc_div(F, BAUD);

  generate
    if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < PARITY_NONE ||
        PARITY > PARITY_EVEN || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
      $fatal(1, "uart_tx_param: illegal parameter combination");
    end
  endgenerate

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  uart_state_e          state;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic [3:0]           bit_idx;
  logic                 tick;
  logic                 baud_clear;
  logic                 last_stop;

  // Counter sits at zero in IDLE and wraps on tick, so every state starts at count 0.
  assign baud_clear = (state == ST_IDLE);

  uart_baud_gen #(
    .DIV(DIV)
  ) u_baud_gen (
    .clk  (clk),
    .rst  (rst),
    .clear(baud_clear),
    .tick (tick)
  );

  assign ready     = (state == ST_IDLE);
  assign last_stop = (bit_idx == LAST_STOP);
  // Decoded from registers only: high for the single clk where the last stop bit ends.
  assign done      = (state == ST_STOP) && last_stop && tick;

  // NOTE: the shift register is reset along with the control state even though
  // its contents are only meaningful mid-frame; it is a handful of flops, not a
  // memory array, so a deterministic post-reset value costs nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      tx      <= 1'b1;
      shreg   <= '0;
      par_bit <= 1'b0;
      bit_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          tx      <= 1'b1;
          bit_idx <= '0;
          if (valid) begin
            shreg   <= data;
            par_bit <= parity_of(9'(data), PARITY);
            tx      <= 1'b0;
            state   <= ST_START;
          end
        end

        ST_START: begin
          if (tick) begin
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
            state   <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (tick) begin
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
              if (PARITY != PARITY_NONE) begin
                tx    <= par_bit;
                state <= ST_PAR;
              end else begin
                tx    <= 1'b1;
                state <= ST_STOP;
              end
            end else begin
              bit_idx <= bit_idx + 4'd1;
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end

        ST_PAR: begin
          if (tick) begin
            tx      <= 1'b1;
            bit_idx <= '0;
            state   <= ST_STOP;
          end
        end

        ST_STOP: begin
          tx <= 1'b1;
          if (tick) begin
            if (last_stop) begin
              bit_idx <= '0;
              state   <= ST_IDLE;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end

        default: begin
          tx      <= 1'b1;
          bit_idx <= '0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: randomized drivers push expected frames,
// per-instance line monitors decode tx clk by clk against a reference bit model.
`timescale 1ns/1ps
module tb_uart_tx_param;

  localparam int N = 5;
  localparam int F_HZ   [N] = '{1000, 1000, 1000, 50000000, 2000};
  localparam int BAUD_R [N] = '{100,  100,  100,  115200,   1000};
  localparam int DBITS  [N] = '{8,    7,    7,    8,        9};
  localparam int PMODE  [N] = '{0,    2,    1,    0,        2};
  localparam int SBITS  [N] = '{1,    2,    2,    1,        1};

  typedef struct {
    logic [8:0] data;
    int         acc_edge;
    bit         b2b;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_w [N];
  logic       ready_w [N];
  logic       tx_w    [N];
  logic       done_w  [N];
  logic [8:0] data_w  [N];
  int         cyc = 0;

  exp_t sb_q [N][$];
  bit   drv_done [N];
  int   spurious_done [N];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : g_dut
    uart_tx_param #(
      .F(F_HZ[g]), .BAUD(BAUD_R[g]), .DATA_BITS(DBITS[g]),
      .PARITY(PMODE[g]), .STOP_BITS(SBITS[g])
    ) u_dut (
      .clk  (clk),
      .rst  (rst),
      .data (data_w[g][DBITS[g]-1:0]),
      .valid(valid_w[g]),
      .ready(ready_w[g]),
      .tx   (tx_w[g]),
      .done (done_w[g])
    );
  end

  task automatic check(input string name, input bit ok, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic int div_of(input int id);
    return (F_HZ[id] + BAUD_R[id] / 2) / BAUD_R[id];
  endfunction

  function automatic int frame_bits(input int id);
    return 1 + DBITS[id] + ((PMODE[id] != 0) ? 1 : 0) + SBITS[id];
  endfunction

  // Reference line level for bit position pos of a frame carrying d.
  function automatic logic line_bit(input int id, input logic [8:0] d, input int pos);
    int ones;
    ones = $countones(d);
    if (pos == 0) return 1'b0;
    if (pos <= DBITS[id]) return d[pos-1];
    if (PMODE[id] != 0 && pos == DBITS[id] + 1)
      return (PMODE[id] == 2) ? 1'(ones % 2) : 1'(1 - ones % 2);
    return 1'b1;
  endfunction

  task automatic drive(input int id, input int n, input bit hold, input int d0, input int d1);
    int         acc;
    logic [8:0] mask;
    logic [8:0] d;
    acc  = 0;
    mask = 9'((1 << DBITS[id]) - 1);
    while (acc < n) begin
      @(negedge clk);
      d = 9'($urandom) & mask;
      if (acc == 0 && d0 >= 0) d = 9'(d0) & mask;
      if (acc == 1 && d1 >= 0) d = 9'(d1) & mask;
      data_w[id]  = d;
      valid_w[id] = hold ? 1'b1 : ($urandom_range(0, 2) == 0);
      if (valid_w[id] && ready_w[id]) begin
        sb_q[id].push_back('{d, cyc + 1, hold && acc > 0});
        acc++;
      end
    end
    @(negedge clk);
    valid_w[id]  = 1'b0;
    data_w[id]   = 9'($urandom);
    drv_done[id] = 1'b1;
  endtask

  task automatic monitor(input int id);
    int   div, nb, flen, idle, prev_s, s;
    int   bad_tx, bad_rdy, bad_done, first_bad;
    exp_t it;
    div    = div_of(id);
    nb     = frame_bits(id);
    flen   = div * nb;
    idle   = 0;
    prev_s = -1;
    while (idle <= 2 * flen + 4) begin
      @(negedge clk);
      if (tx_w[id] === 1'b0) begin
        idle = 0;
        s    = cyc;
        if (sb_q[id].size() == 0) begin
          check($sformatf("unexpected_frame[%0d]", id), 1'b0, s, -1);
          repeat (flen) @(negedge clk);
        end else begin
          it = sb_q[id].pop_front();
          check($sformatf("start_latency[%0d]", id), s == it.acc_edge, s, it.acc_edge);
          if (it.b2b)
            check($sformatf("b2b_spacing[%0d]", id), (s - prev_s) == flen + 1, s - prev_s, flen + 1);
          prev_s    = s;
          bad_tx    = 0;
          bad_rdy   = 0;
          bad_done  = 0;
          first_bad = -1;
          for (int p = 0; p < nb; p++) begin
            for (int k = 0; k < div; k++) begin
              if (p != 0 || k != 0) @(negedge clk);
              if (tx_w[id] !== line_bit(id, it.data, p)) begin
                bad_tx++;
                if (first_bad < 0) first_bad = p * div + k;
              end
              if (ready_w[id] !== 1'b0) bad_rdy++;
              if (done_w[id] !== ((p == nb - 1 && k == div - 1) ? 1'b1 : 1'b0)) bad_done++;
            end
          end
          check($sformatf("frame_tx[%0d] data=0x%0h first_bad_clk=%0d bad_clks", id, it.data, first_bad),
                bad_tx == 0, bad_tx, 0);
          check($sformatf("ready_low_in_frame[%0d] bad_clks", id), bad_rdy == 0, bad_rdy, 0);
          check($sformatf("done_pulse[%0d] bad_clks", id), bad_done == 0, bad_done, 0);
          @(negedge clk);
          check($sformatf("idle_after_frame[%0d] {tx,ready,done}", id),
                {tx_w[id], ready_w[id], done_w[id]} === 3'b110,
                {tx_w[id], ready_w[id], done_w[id]}, 3'b110);
        end
      end else begin
        if (done_w[id] !== 1'b0) spurious_done[id]++;
        if (drv_done[id]) idle++;
      end
    end
    check($sformatf("scoreboard_empty[%0d]", id), sb_q[id].size() == 0, sb_q[id].size(), 0);
    check($sformatf("spurious_done[%0d]", id), spurious_done[id] == 0, spurious_done[id], 0);
  endtask

  task automatic run_phase(input bit [N-1:0] en, input bit hold);
    for (int i = 0; i < N; i++) begin
      drv_done[i]      = 1'b0;
      spurious_done[i] = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (en[i]) begin
        automatic int id = i;
        automatic int n  = (id == 3) ? 1 : (hold ? 3 : 6);
        automatic int d0 = hold ? ((id == 0) ? 'hA5 : -1) : ((id == 0) ? 'h55 : ((id == 1 || id == 2) ? 'h03 : -1));
        automatic int d1 = (hold && id == 0) ? 'h3C : -1;
        fork
          drive(id, n, hold, d0, d1);
          monitor(id);
        join_none
      end
    end
    wait fork;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         acc_cyc;
    logic [8:0] rd;
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      valid_w[i] = 1'b0;
      data_w[i]  = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      valid_w[i] = 1'b1;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("reset_tx[%0d]", i), tx_w[i] === 1'b1, tx_w[i], 1);
      check($sformatf("reset_ready[%0d]", i), ready_w[i] === 1'b1, ready_w[i], 1);
      check($sformatf("reset_done[%0d]", i), done_w[i] === 1'b0, done_w[i], 0);
      valid_w[i] = 1'b0;
    end
    rst = 1'b0;

    run_phase(5'b11111, 1'b0);
    run_phase(5'b00011, 1'b1);

    // Reset mid-frame during data bit 4 of instance 0.
    @(negedge clk);
    rd          = 9'h04A;
    data_w[0]   = rd;
    valid_w[0]  = 1'b1;
    check("rst_test_ready_before_accept", ready_w[0] === 1'b1, ready_w[0], 1);
    acc_cyc     = cyc;
    @(negedge clk);
    valid_w[0]  = 1'b0;
    check("rst_test_start_low", tx_w[0] === 1'b0, tx_w[0], 0);
    repeat (div_of(0) * 5 + 3) @(negedge clk);
    check("rst_test_in_bit4", tx_w[0] === line_bit(0, rd, 5) && (cyc - acc_cyc) == div_of(0) * 5 + 4,
          cyc - acc_cyc, div_of(0) * 5 + 4);
    #1 rst = 1'b1;
    valid_w[0] = 1'b1;
    #1;
    check("rst_async_tx", tx_w[0] === 1'b1, tx_w[0], 1);
    check("rst_async_ready", ready_w[0] === 1'b1, ready_w[0], 1);
    check("rst_async_done", done_w[0] === 1'b0, done_w[0], 0);
    repeat (3) @(negedge clk);
    check("rst_held_no_accept", {tx_w[0], ready_w[0], done_w[0]} === 3'b110,
          {tx_w[0], ready_w[0], done_w[0]}, 3'b110);
    valid_w[0] = 1'b0;
    rst        = 1'b0;
    @(negedge clk);
    check("rst_release_idle", {tx_w[0], ready_w[0], done_w[0]} === 3'b110,
          {tx_w[0], ready_w[0], done_w[0]}, 3'b110);

    run_phase(5'b00001, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
